// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller.
package hazard_ctrl_pkg;

   // Halt sequencing states.
   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } hz_state_t;

   // Enable/flush pair driven into one pipeline register.
   typedef struct packed {
      logic en;
      logic flush;
   } stage_ctrl_t;

   // Register number that never carries a real dependency.
   localparam logic [4:0] REG_ZERO = 5'd0;

   // Strobe pair for a stage that simply advances.
   localparam stage_ctrl_t STAGE_RUN  = '{en: 1'b1, flush: 1'b0};
   // Strobe pair for a stage that is frozen.
   localparam stage_ctrl_t STAGE_HOLD = '{en: 1'b0, flush: 1'b0};
   // Strobe pair for a stage that loads a bubble.
   localparam stage_ctrl_t STAGE_KILL = '{en: 1'b1, flush: 1'b1};

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic         at_max;

   assign at_max = &cnt_q;

   // Next count: clear wins, otherwise step unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && !at_max) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i) begin
      cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes, halt drain and
// saturating stall/bubble counters for the 5-stage core.
//
// state  | meaning
// -------+---------------------------------------------------------------
// RUN    | normal operation, hazards resolved in priority order
// DRAIN  | halt instruction writes back, only MEM/WB advances
// HALTED | terminal, everything frozen until reset
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dmemREN_MEM,
   input  logic             dmemWEN_MEM,
   input  logic             memtoReg_EX,
   input  logic [4:0]       final_wsel_EX,
   input  logic [4:0]       rs_ID,
   input  logic [4:0]       rt_ID,
   input  logic             uses_rt_ID,
   input  logic             jump_ID,
   input  logic             branch_taken_EX,
   input  logic             halt_MEM,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   // A load in EX feeds a source of the ID instruction; $0 never counts.
   function automatic logic load_use_hit(
      input logic       mem_to_reg,
      input logic [4:0] wsel,
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic       uses_rt
   );
      logic dep_rs;
      logic dep_rt;
      dep_rs = (wsel == rs);
      dep_rt = uses_rt && (wsel == rt);
      return mem_to_reg && (wsel != REG_ZERO) && (dep_rs || dep_rt);
   endfunction

   hz_state_t   state_q;
   hz_state_t   state_d;

   logic        d_stall;
   logic        load_use;
   logic        jump_go;

   logic        pc_c;
   stage_ctrl_t ifid_c;
   stage_ctrl_t idex_c;
   stage_ctrl_t exmem_c;
   stage_ctrl_t memwb_c;

   logic        stall_inc;
   logic        bubble_inc;
   logic        cnt_clr;

   assign d_stall  = (dmemREN_MEM || dmemWEN_MEM) && !dhit;
   assign load_use = load_use_hit(memtoReg_EX, final_wsel_EX, rs_ID, rt_ID, uses_rt_ID);
   assign jump_go  = jump_ID && ihit;

   // State register with synchronous active-low reset.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: halt may only leave RUN once the data access is not stalling.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (halt_MEM && !d_stall) begin
               state_d = DRAIN;
            end
         end
         DRAIN:   state_d = HALTED;
         HALTED:  state_d = HALTED;
         default: state_d = RUN;
      endcase
   end

   // Stage strobes: Mealy decode of state and current hazards.
   always_comb begin
      pc_c    = 1'b1;
      ifid_c  = STAGE_RUN;
      idex_c  = STAGE_RUN;
      exmem_c = STAGE_RUN;
      memwb_c = STAGE_RUN;

      unique case (state_q)
         RUN: begin
            if (d_stall) begin
               // Hold everything upstream of MEM so pending hazards survive.
               pc_c         = 1'b0;
               ifid_c       = STAGE_HOLD;
               idex_c       = STAGE_HOLD;
               exmem_c      = STAGE_HOLD;
               memwb_c      = STAGE_KILL;
            end else if (halt_MEM) begin
               // HALT moves on to MEM/WB; a bubble follows it into MEM.
               pc_c         = 1'b0;
               ifid_c       = STAGE_HOLD;
               idex_c       = STAGE_HOLD;
               exmem_c      = STAGE_KILL;
            end else if (branch_taken_EX) begin
               // Load the target even during an I-miss; the fetch is discarded.
               ifid_c.flush = 1'b1;
               idex_c.flush = 1'b1;
            end else if (load_use) begin
               // Wins over jump: a JR may depend on the loaded register.
               pc_c         = 1'b0;
               ifid_c       = STAGE_HOLD;
               idex_c       = STAGE_KILL;
            end else if (jump_go) begin
               ifid_c.flush = 1'b1;
            end else if (!ihit) begin
               pc_c         = 1'b0;
               ifid_c.flush = 1'b1;
            end
         end
         DRAIN: begin
            pc_c    = 1'b0;
            ifid_c  = STAGE_HOLD;
            idex_c  = STAGE_HOLD;
            exmem_c = STAGE_HOLD;
         end
         default: begin
            pc_c    = 1'b0;
            ifid_c  = STAGE_HOLD;
            idex_c  = STAGE_HOLD;
            exmem_c = STAGE_HOLD;
            memwb_c = STAGE_HOLD;
         end
      endcase

      // Nothing in the pipeline may move while reset is held.
      if (!nRST) begin
         pc_c    = 1'b0;
         ifid_c  = STAGE_HOLD;
         idex_c  = STAGE_HOLD;
         exmem_c = STAGE_HOLD;
         memwb_c = STAGE_HOLD;
      end
   end

   assign pc_en       = pc_c;
   assign ifid_en     = ifid_c.en;
   assign idex_en     = idex_c.en;
   assign exmem_en    = exmem_c.en;
   assign memwb_en    = memwb_c.en;
   assign ifid_flush  = ifid_c.flush;
   assign idex_flush  = idex_c.flush;
   assign exmem_flush = exmem_c.flush;
   assign memwb_flush = memwb_c.flush;
   assign halted      = nRST && (state_q == HALTED);

   // Counters only observe RUN cycles; reset clears them synchronously.
   assign cnt_clr    = !nRST;
   assign stall_inc  = nRST && (state_q == RUN) && !pc_c;
   assign bubble_inc = nRST && (state_q == RUN) && idex_c.flush;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk_i (CLK),
      .clr_i (cnt_clr),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_bubble_cnt (
      .clk_i (CLK),
      .clr_i (cnt_clr),
      .inc_i (bubble_inc),
      .cnt_o (bubble_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a behavioural model pushes expected
// strobes/counters per cycle, the DUT outputs are popped and compared mid-cycle.
module tb_hazard_ctrl;

   localparam int CNT_W = 4;
   localparam int MAXC  = (1 << CNT_W) - 1;

   logic             CLK;
   logic             nRST;
   logic             ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memtoReg_EX;
   logic [4:0]       final_wsel_EX, rs_ID, rt_ID;
   logic             uses_rt_ID, jump_ID, branch_taken_EX, halt_MEM;
   logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
   logic             ifid_flush, idex_flush, exmem_flush, memwb_flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt, bubble_cnt;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
      .dmemREN_MEM(dmemREN_MEM), .dmemWEN_MEM(dmemWEN_MEM),
      .memtoReg_EX(memtoReg_EX), .final_wsel_EX(final_wsel_EX),
      .rs_ID(rs_ID), .rt_ID(rt_ID), .uses_rt_ID(uses_rt_ID),
      .jump_ID(jump_ID), .branch_taken_EX(branch_taken_EX), .halt_MEM(halt_MEM),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .exmem_flush(exmem_flush), .memwb_flush(memwb_flush), .halted(halted),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [8:0] strb;
      logic       hlt;
      int         stall;
      int         bubble;
   } exp_t;

   exp_t sb_q[$];

   int checks   = 0;
   int failures = 0;

   // model: 0=RUN 1=DRAIN 2=HALTED
   int m_state  = 0;
   int m_stall  = 0;
   int m_bubble = 0;

   task automatic hz_chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // {pc, ifid_en, idex_en, exmem_en, memwb_en, ifid_fl, idex_fl, exmem_fl, memwb_fl}
   function automatic logic [8:0] model_strobes();
      logic lu;
      if (!nRST) return 9'b00000_0000;
      if (m_state == 1) return 9'b00001_0000;
      if (m_state == 2) return 9'b00000_0000;
      lu = memtoReg_EX && (final_wsel_EX != 0) &&
           ((final_wsel_EX == rs_ID) || (uses_rt_ID && (final_wsel_EX == rt_ID)));
      if ((dmemREN_MEM || dmemWEN_MEM) && !dhit) return 9'b00001_0001;
      if (halt_MEM)                              return 9'b00011_0010;
      if (branch_taken_EX)                       return 9'b11111_1100;
      if (lu)                                    return 9'b00111_0100;
      if (jump_ID && ihit)                       return 9'b11111_1000;
      if (!ihit)                                 return 9'b01111_1000;
      return 9'b11111_0000;
   endfunction

   task automatic tick();
      exp_t e;
      exp_t got;
      e.strb   = model_strobes();
      e.hlt    = nRST && (m_state == 2);
      e.stall  = m_stall;
      e.bubble = m_bubble;
      sb_q.push_back(e);
      @(negedge CLK);
      got = sb_q.pop_front();
      hz_chk("strobes", {23'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                         ifid_flush, idex_flush, exmem_flush, memwb_flush}, {23'd0, got.strb});
      hz_chk("halted", {31'd0, halted}, {31'd0, got.hlt});
      hz_chk("stall_cnt", {28'd0, stall_cnt}, got.stall);
      hz_chk("bubble_cnt", {28'd0, bubble_cnt}, got.bubble);
      @(posedge CLK);
      if (!nRST) begin
         m_state = 0; m_stall = 0; m_bubble = 0;
      end else if (m_state == 0) begin
         if (!e.strb[8] && m_stall < MAXC) m_stall++;
         if (e.strb[2] && m_bubble < MAXC) m_bubble++;
         if (halt_MEM && !((dmemREN_MEM || dmemWEN_MEM) && !dhit)) m_state = 1;
      end else begin
         m_state = 2;
      end
      #1;
   endtask

   task automatic idle_inputs();
      ihit = 1; dhit = 1; dmemREN_MEM = 0; dmemWEN_MEM = 0; memtoReg_EX = 0;
      final_wsel_EX = 0; rs_ID = 0; rt_ID = 0; uses_rt_ID = 0;
      jump_ID = 0; branch_taken_EX = 0; halt_MEM = 0;
   endtask

   initial begin
      nRST = 0;
      idle_inputs();
      @(posedge CLK);
      #1;
      repeat (2) tick();
      hz_chk("rst_stall", {28'd0, stall_cnt}, 0);
      nRST = 1;
      repeat (2) tick();

      // load-use on rs
      memtoReg_EX = 1; final_wsel_EX = 5'd2; rs_ID = 5'd2;
      tick();
      hz_chk("lu_bubble", {28'd0, bubble_cnt}, 1);
      hz_chk("lu_stall", {28'd0, stall_cnt}, 1);
      // load-use on rt, then rt not used
      rs_ID = 0; rt_ID = 5'd5; final_wsel_EX = 5'd5; uses_rt_ID = 1;
      tick();
      uses_rt_ID = 0;
      tick();
      // load-use beats jump, jump next cycle
      rs_ID = 5'd5; jump_ID = 1;
      tick();
      memtoReg_EX = 0;
      tick();
      idle_inputs();

      // branch during I-miss
      branch_taken_EX = 1; ihit = 0;
      tick();
      hz_chk("br_stall", {28'd0, stall_cnt}, m_stall);
      branch_taken_EX = 0;
      tick();
      idle_inputs();

      // D-stall masking a load-use for 3 cycles
      dmemREN_MEM = 1; dhit = 0; memtoReg_EX = 1; final_wsel_EX = 5'd7; rs_ID = 5'd7;
      repeat (3) tick();
      dhit = 1;
      tick();
      idle_inputs();
      dmemWEN_MEM = 1; dhit = 0;
      tick();
      idle_inputs();

      // stall counter saturation
      ihit = 0;
      repeat (20) tick();
      hz_chk("sat_stall", {28'd0, stall_cnt}, 15);
      idle_inputs();

      // mixed traffic, no halt
      for (int i = 0; i < 40; i++) begin
         ihit            = 1'($urandom_range(0, 1));
         dhit            = 1'($urandom_range(0, 1));
         dmemREN_MEM     = 1'($urandom_range(0, 1));
         dmemWEN_MEM     = 1'($urandom_range(0, 3) == 0);
         memtoReg_EX     = 1'($urandom_range(0, 1));
         final_wsel_EX   = 5'($urandom_range(0, 3));
         rs_ID           = 5'($urandom_range(0, 3));
         rt_ID           = 5'($urandom_range(0, 3));
         uses_rt_ID      = 1'($urandom_range(0, 1));
         jump_ID         = 1'($urandom_range(0, 1));
         branch_taken_EX = 1'($urandom_range(0, 3) == 0);
         tick();
      end
      idle_inputs();

      // halt blocked by a D-stall, then taken
      halt_MEM = 1; dmemREN_MEM = 1; dhit = 0;
      tick();
      dhit = 1;
      tick();
      halt_MEM = 0; dmemREN_MEM = 0;
      tick();
      repeat (12) tick();
      hz_chk("halted_sticky", {31'd0, halted}, 1);

      // reset from HALTED, then $0 load-use pattern
      nRST = 0;
      tick();
      nRST = 1;
      hz_chk("post_rst_halted", {31'd0, halted}, 0);
      hz_chk("post_rst_bubble", {28'd0, bubble_cnt}, 0);
      memtoReg_EX = 1; final_wsel_EX = 5'd0; rs_ID = 5'd0; rt_ID = 5'd0; uses_rt_ID = 1;
      tick();
      hz_chk("zero_reg_pc_en", {31'd0, pc_en}, 1);
      idle_inputs();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
